alu16_sequencer: RTL and testbench
==================================

# alu16_sequencer

Sequences 16-bit arithmetic (ADD16, SUB16, INC16, DEC16) over the 8-bit `alu` by issuing a low-byte operation followed by a high-byte carry/borrow-chained operation. It sits between the instruction decoder / register file and `alu`: it drives the ALU's operand and control inputs while busy, consumes `o_data`/`o_flags`, and returns a 16-bit result plus a Game Boy style flag nibble {Z,N,H,C}.

## Interface
- `DATA_WIDTH`, 8: ALU byte width; the result is 2×DATA_WIDTH.
- `OPCODE_WIDTH`, 3: width of the ALU control bus.
- `i_clk`  in  1  clock, shared with `alu`.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_op`  in  2  00 ADD16, 01 SUB16, 10 INC16, 11 DEC16.
- `i_operand_A`  in  16  first operand (HL / rr).
- `i_operand_B`  in  16  second operand; ignored for INC16/DEC16.
- `i_flags_in`  in  4  current CPU flags {Z,N,H,C}.
- `o_alu_sel`  out  1  high while the sequencer owns the ALU inputs (datapath mux select).
- `o_alu_A`, `o_alu_B`  out  8  ALU operands.
- `o_alu_control`  out  3  ALU opcode.
- `i_alu_data`  in  8  ALU `o_data`.
- `i_alu_flags`  in  4  ALU `o_flags`.
- `o_busy`  out  1  high from LO through CAP.
- `o_done`  out  1  one-cycle completion pulse.
- `o_result`  out  16  result; held until the next accepted start.
- `o_flags`  out  4  resulting flags; held with `o_result`.

## Operation
- FSM states: IDLE → LO → HI → CAP → DONE → IDLE.
  - Each non-IDLE state lasts exactly one cycle.
  - `i_start` is ignored in every state other than IDLE.
- IDLE: on `i_start`, latch `i_op`, operands and `i_flags_in`.
- LO: drive the low bytes.
  - ADD16/INC16: control 000 (ADD).
  - SUB16/DEC16: control 010 (SUB).
  - INC16/DEC16 use B low byte = 0x01.
- HI: drive the high bytes.
  - ADD16/INC16: control 001 (ADC). SUB16/DEC16: control 011 (SBC).
  - INC16/DEC16 use B high byte = 0x00.
  - The ALU carry-in is its own registered C from the LO operation.
  - Capture `i_alu_data` into `o_result[7:0]`; record low-byte zero.
- CAP: capture `i_alu_data` into `o_result[15:8]` and `i_alu_flags` into the high-byte flags.
- DONE: `o_done` = 1; `o_result` and `o_flags` are valid from this cycle.
- Flag rules:
  - ADD16: Z = latched Z; N = 0; H, C from the high byte.
  - SUB16: Z = (result == 0x0000); N = 1; H, C from the high byte.
  - INC16/DEC16: flags = latched `i_flags_in`, unchanged.
- Arithmetic wraps modulo 2^16; there is no overflow indication beyond C.
- `o_alu_sel` = 1 in LO, HI and CAP. When `o_alu_sel` = 0, `o_alu_A`, `o_alu_B` and `o_alu_control` drive 0.

## Timing
- `i_start` sampled at edge n → LO in cycle n+1 → `o_done` high in cycle n+4.
- Next start is accepted at edge n+5 at the earliest.
- The ALU is assumed to register its outputs with 1-cycle latency. The low result is visible during HI; the high result is visible during CAP.
- Reset values (all outputs, asynchronous): `o_busy`, `o_done`, `o_alu_sel` = 0; `o_alu_A`, `o_alu_B`, `o_alu_control` = 0; `o_result` = 0x0000; `o_flags` = 4'b0000; state = IDLE.
- Reset mid-operation aborts immediately; no `o_done` is produced.
- Operand changes after acceptance have no effect.

## Configuration
- `ALU16_SUB_EN` defined: SUB16 and DEC16 execute as described above.
- `ALU16_SUB_EN` undefined: ops 01 and 11 are treated as NOPs.
  - FSM goes IDLE → DONE.
  - `o_done` is high at cycle n+1.
  - `o_result` = `i_operand_A`; `o_flags` = `i_flags_in`.
  - `o_alu_sel` and `o_busy` stay 0.

## Test plan
- ADD16, A = 0x0FFF, B = 0x0001, flags_in = 1000 → `o_result` 0x1000, `o_flags` 1010, `o_done` at n+4.
- ADD16, A = 0xFFFF, B = 0x0001, flags_in = 0000 → 0x0000, flags 0011 (Z preserved, not set).
- SUB16, A = 0x1000, B = 0x0001 → 0x0FFF, flags 0110. SUB16, A = 0x1234, B = 0x1234 → 0x0000, flags 1100.
- DEC16, A = 0x0000, flags_in = 1111 → 0xFFFF, flags 1111. INC16, A = 0x00FF → 0x0100, flags unchanged.
- `i_start` pulsed during HI with different operands → ignored; the original result completes unchanged.
- `i_rst` asserted during HI → all outputs 0 in the same cycle, no `o_done`. A fresh ADD16 afterwards completes correctly.
- Build without `ALU16_SUB_EN`: SUB16 with A = 0x1234, flags_in = 0101 → `o_done` at n+1, result 0x1234, flags 0101, `o_alu_sel` never 1.

Source files
------------

// File: rtl/alu16_sequencer.sv
// ---------------------------------------------------------------------------
// alu16_sequencer
//
// Runs a 16-bit ADD16 / SUB16 / INC16 / DEC16 as two byte operations on the
// shared 8-bit ALU. The low bytes go first with ADD/SUB. The high bytes follow
// with ADC/SBC, which use the carry the ALU registered during the low-byte op.
// The block returns a 16-bit result and a {Z,N,H,C} flag nibble.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_op         request (sampled in IDLE only), op select
//   i_operand_A/B         16-bit operands (B unused for INC16/DEC16)
//   i_flags_in            current CPU flags {Z,N,H,C}
//   o_alu_sel             sequencer owns the ALU inputs (LO, HI, CAP)
//   o_alu_A/B/control     ALU operand and opcode drive (0 when not selected)
//   i_alu_data/flags      registered ALU result and flags
//   o_busy, o_done        busy LO..CAP, one-cycle completion pulse
//   o_result, o_flags     result and flags, held until the next accepted start
//
// Build option
//   ALU16_SUB_EN  defined: SUB16/DEC16 run through the ALU.
//                 undefined: ops 01/11 complete in one cycle as NOPs
//                 (result = operand A, flags = flags in, ALU untouched).
// ---------------------------------------------------------------------------
module alu16_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [1:0]                i_op,
  input  logic [2*DATA_WIDTH-1:0]   i_operand_A,
  input  logic [2*DATA_WIDTH-1:0]   i_operand_B,
  input  logic [3:0]                i_flags_in,
  output logic                      o_alu_sel,
  output logic [DATA_WIDTH-1:0]     o_alu_A,
  output logic [DATA_WIDTH-1:0]     o_alu_B,
  output logic [OPCODE_WIDTH-1:0]   o_alu_control,
  input  logic [DATA_WIDTH-1:0]     i_alu_data,
  input  logic [3:0]                i_alu_flags,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_result,
  output logic [3:0]                o_flags
);

  localparam int W2 = 2 * DATA_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] CTL_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] CTL_ADC = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] CTL_SUB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] CTL_SBC = OPCODE_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a_hi;
  logic [DATA_WIDTH-1:0]   r_b_hi;
  logic [3:0]              r_flags_in;
  logic                    r_lo_zero;

  logic                    r_alu_sel;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic [OPCODE_WIDTH-1:0] r_alu_ctl;
  logic                    r_busy;
  logic                    r_done;
  logic [W2-1:0]           r_result;
  logic [3:0]              r_flags;

  logic w_start_nop;
  logic w_op_sub;     // op[0]: SUB16 / DEC16
  logic w_op_incdec;  // op[1]: INC16 / DEC16 (implicit +/-1, flags pass through)
  logic w_unused_alu_n;

`ifdef ALU16_SUB_EN
  assign w_start_nop = 1'b0;
`else
  assign w_start_nop = i_op[0];
`endif

  assign w_op_sub       = r_op[0];
  assign w_op_incdec    = r_op[1];
  // The ALU N flag is never needed: N is fixed by the 16-bit op.
  assign w_unused_alu_n = i_alu_flags[2];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_a_hi     <= '0;
      r_b_hi     <= '0;
      r_flags_in <= 4'b0000;
      r_lo_zero  <= 1'b0;
      r_alu_sel  <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctl  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_flags    <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op       <= i_op;
            r_a_hi     <= i_operand_A[W2-1:DATA_WIDTH];
            r_b_hi     <= i_operand_B[W2-1:DATA_WIDTH];
            r_flags_in <= i_flags_in;
            if (w_start_nop) begin
              r_result <= i_operand_A;
              r_flags  <= i_flags_in;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              // Low-byte operands are driven straight from the request so the
              // ALU sees them during LO.
              r_alu_sel <= 1'b1;
              r_busy    <= 1'b1;
              r_alu_a   <= i_operand_A[DATA_WIDTH-1:0];
              r_alu_b   <= i_op[1] ? DATA_WIDTH'(1) : i_operand_B[DATA_WIDTH-1:0];
              r_alu_ctl <= i_op[0] ? CTL_SUB : CTL_ADD;
              r_state   <= S_LO;
            end
          end
        end

        S_LO: begin
          r_alu_a   <= r_a_hi;
          r_alu_b   <= w_op_incdec ? '0 : r_b_hi;
          r_alu_ctl <= w_op_sub ? CTL_SBC : CTL_ADC;
          r_state   <= S_HI;
        end

        S_HI: begin
          // Low-byte result from the LO operation is on the ALU outputs now.
          r_result[DATA_WIDTH-1:0] <= i_alu_data;
          r_lo_zero                <= (i_alu_data == '0);
          r_state                  <= S_CAP;
        end

        S_CAP: begin
          r_result[W2-1:DATA_WIDTH] <= i_alu_data;
          if (w_op_incdec) begin
            r_flags <= r_flags_in;
          end else if (w_op_sub) begin
            r_flags <= {r_lo_zero & i_alu_flags[3], 1'b1, i_alu_flags[1], i_alu_flags[0]};
          end else begin
            // ADD16 keeps the incoming Z; it is not recomputed from the result.
            r_flags <= {r_flags_in[3], 1'b0, i_alu_flags[1], i_alu_flags[0]};
          end
          r_alu_sel <= 1'b0;
          r_busy    <= 1'b0;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_alu_ctl <= '0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_alu_sel     = r_alu_sel;
  assign o_alu_A       = r_alu_a;
  assign o_alu_B       = r_alu_b;
  assign o_alu_control = r_alu_ctl;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_flags       = r_flags;

endmodule

// File: tb/tb_alu16_sequencer.sv
module tb_alu16_sequencer;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [15:0] i_operand_A;
  logic [15:0] i_operand_B;
  logic [3:0]  i_flags_in;
  logic        o_alu_sel;
  logic [7:0]  o_alu_A;
  logic [7:0]  o_alu_B;
  logic [2:0]  o_alu_control;
  logic [7:0]  alu_data;
  logic [3:0]  alu_flags;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic [3:0]  o_flags;

`ifdef ALU16_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  alu16_sequencer #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_operand_A   (i_operand_A),
    .i_operand_B   (i_operand_B),
    .i_flags_in    (i_flags_in),
    .o_alu_sel     (o_alu_sel),
    .o_alu_A       (o_alu_A),
    .o_alu_B       (o_alu_B),
    .o_alu_control (o_alu_control),
    .i_alu_data    (alu_data),
    .i_alu_flags   (alu_flags),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_flags       (o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 8-bit ALU: registered outputs, ADC/SBC use its own stored C.
  function automatic logic [11:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] ctl, input logic cin);
    int ai, bi, ci, res;
    logic h, cy, n;
    logic [7:0] r;
    ai = int'(a);
    bi = int'(b);
    ci = (ctl[0] && cin) ? 1 : 0;
    if (ctl[2]) return 12'h000;
    if (!ctl[1]) begin
      res = ai + bi + ci;
      h   = ((ai & 15) + (bi & 15) + ci) > 15;
      cy  = res > 255;
      n   = 1'b0;
    end else begin
      res = ai - bi - ci;
      h   = (ai & 15) < ((bi & 15) + ci);
      cy  = ai < (bi + ci);
      n   = 1'b1;
    end
    r = 8'(res & 255);
    return {(r == 8'h00), n, h, cy, r};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data  <= 8'h00;
      alu_flags <= 4'h0;
    end else begin
      {alu_flags, alu_data} <= alu_eval(o_alu_A, o_alu_B, o_alu_control, alu_flags[0]);
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  flags;
    int          cycle;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every o_done pops one expected response.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 32'(o_result), 32'(e.result));
        chk("flags", 32'(o_flags), 32'(e.flags));
        chk("done_cycle", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb_q.size());
    sb_q.delete();
  endtask

  // Issue one op; er/ef are the expected values with subtraction enabled.
  task automatic run(input string nm, input logic [1:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [3:0] f,
                     input logic [15:0] er, input logic [3:0] ef);
    bit   nop;
    exp_t e;
    nop = !SUB_EN && op[0];
    @(negedge clk);
    i_start = 1'b1;
    i_op = op;
    i_operand_A = a;
    i_operand_B = b;
    i_flags_in = f;
    e.result = nop ? a : er;
    e.flags  = nop ? f : ef;
    e.cycle  = cyc + (nop ? 1 : 4);
    sb_q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    i_operand_A = ~a;
    i_operand_B = ~b;
    i_flags_in = ~f;
    if (nop) begin
      chk({nm, "_nop_sel"}, 32'({o_alu_sel, o_busy}), 32'd0);
    end else begin
      chk({nm, "_lo_bus"}, {8'(o_alu_sel), 8'(o_alu_control), o_alu_A, o_alu_B},
          {8'd1, 8'(op[0] ? 3'b010 : 3'b000), a[7:0], (op[1] ? 8'h01 : b[7:0])});
      @(negedge clk);
      chk({nm, "_hi_bus"}, {8'(o_busy), 8'(o_alu_control), o_alu_A, o_alu_B},
          {8'd1, 8'(op[0] ? 3'b011 : 3'b001), a[15:8], (op[1] ? 8'h00 : b[15:8])});
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    exp_t e;
    rst = 1'b1;
    i_start = 1'b0;
    i_op = 2'b00;
    i_operand_A = 16'h0000;
    i_operand_B = 16'h0000;
    i_flags_in = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", {o_busy, o_done, o_alu_sel, o_alu_A, o_alu_B, o_alu_control, o_result, o_flags},
        38'(0));
    rst = 1'b0;
    @(negedge clk);

    run("add_carry_lo", 2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
    run("add_wrap",     2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
    run("sub_borrow",   2'b01, 16'h1000, 16'h0001, 4'b0000, 16'h0FFF, 4'b0110);
    run("sub_zero",     2'b01, 16'h1234, 16'h1234, 4'b0101, 16'h0000, 4'b1100);
    run("dec_wrap",     2'b11, 16'h0000, 16'hABCD, 4'b1111, 16'hFFFF, 4'b1111);
    run("add_plain",    2'b00, 16'h1234, 16'h4321, 4'b0000, 16'h5555, 4'b0000);
    run("inc_wrap",     2'b10, 16'hFFFF, 16'h1234, 4'b0010, 16'h0000, 4'b0010);
    run("inc_carry",    2'b10, 16'h00FF, 16'h5A5A, 4'b0101, 16'h0100, 4'b0101);

    // Start pulse during HI with other operands must be ignored.
    @(negedge clk);
    i_start = 1'b1;
    i_op = 2'b00;
    i_operand_A = 16'h0FFF;
    i_operand_B = 16'h0001;
    i_flags_in = 4'b1000;
    e.result = 16'h1000;
    e.flags  = 4'b1010;
    e.cycle  = cyc + 4;
    sb_q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    i_op = 2'b10;
    i_operand_A = 16'hAAAA;
    i_operand_B = 16'h5555;
    i_flags_in = 4'b0001;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle("start_in_hi");
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("start_in_hi_no_extra", 32'(done_cnt), 32'(d0));

    // Reset during HI aborts with no done.
    @(negedge clk);
    i_start = 1'b1;
    i_op = 2'b00;
    i_operand_A = 16'h2222;
    i_operand_B = 16'h1111;
    i_flags_in = 4'b1111;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_in_hi", {o_busy, o_done, o_alu_sel, o_alu_A, o_alu_B, o_alu_control, o_result, o_flags},
        38'(0));
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_no_done", 32'(done_cnt), 32'(d0));

    run("add_after_rst", 2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
